// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd unit and its client.
package gcd_pkg;

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eISSUE = 2'd1,
    eWAIT  = 2'd2,
    eOUT   = 2'd3
  } gcd_client_state_e;

endpackage

// File: rtl/gcd_client_sat_ctr.sv
// Latency counter: loads 1, increments on request, sticks at all-ones.
module gcd_client_sat_ctr #(
  parameter int unsigned width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic               inc_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q;

  // Load has priority; increment stops at the maximum value instead of wrapping.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= width_p'(1);
    end else if (inc_i && (count_q != {width_p{1'b1}})) begin
      count_q <= count_q + width_p'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/gcd_client.sv
// Single-outstanding-job initiator for the gcd unit: accept, issue, wait, return.
module gcd_client
  import gcd_pkg::*;
#(
  parameter int unsigned width_p       = 32,
  parameter int unsigned cycle_width_p = 16,
  parameter int unsigned timeout_p     = 1000
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     en_i,
  input  logic                     job_v_i,
  input  logic [width_p-1:0]       job_a_i,
  input  logic [width_p-1:0]       job_b_i,
  output logic                     job_ready_o,
  output logic                     gcd_v_o,
  output logic [width_p-1:0]       gcd_a_o,
  output logic [width_p-1:0]       gcd_b_o,
  input  logic                     gcd_ready_i,
  input  logic                     gcd_v_i,
  input  logic [width_p-1:0]       gcd_data_i,
  output logic                     gcd_yumi_o,
  output logic                     res_v_o,
  output logic [width_p-1:0]       res_a_o,
  output logic [width_p-1:0]       res_b_o,
  output logic [width_p-1:0]       res_gcd_o,
  output logic [cycle_width_p-1:0] res_cycles_o,
  input  logic                     res_yumi_i,
  output logic [31:0]              done_count_o,
  output logic                     error_o
);

  gcd_client_state_e        state_q;
  logic [width_p-1:0]       a_q;
  logic [width_p-1:0]       b_q;
  logic [width_p-1:0]       res_gcd_q;
  logic [cycle_width_p-1:0] res_cycles_q;
  logic [31:0]              done_count_q;
  logic                     error_q;
  logic [cycle_width_p-1:0] cyc;
  logic                     issue_fire;
  logic                     wait_idle;

  // Handshake decodes straight from the state register.
  assign job_ready_o = (state_q == eIDLE) && en_i;
  assign gcd_v_o     = (state_q == eISSUE);
  assign gcd_yumi_o  = (state_q == eWAIT) && gcd_v_i;
  assign res_v_o     = (state_q == eOUT);
  assign issue_fire  = gcd_v_o && gcd_ready_i;
  assign wait_idle   = (state_q == eWAIT) && !gcd_v_i;

  // Issue-to-result cycle count; starts at 1 on the issue handshake.
  gcd_client_sat_ctr #(
    .width_p (cycle_width_p)
  ) u_cyc (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (issue_fire),
    .inc_i     (wait_idle),
    .count_o   (cyc)
  );

  // Job FSM plus operand, result, completion and timeout registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= eIDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_gcd_q    <= '0;
      res_cycles_q <= '0;
      done_count_q <= '0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        eIDLE: begin
          if (job_ready_o && job_v_i) begin
            a_q     <= job_a_i;
            b_q     <= job_b_i;
            state_q <= eISSUE;
          end
        end
        eISSUE: begin
          if (gcd_ready_i) begin
            state_q <= eWAIT;
          end
        end
        eWAIT: begin
          if (gcd_v_i) begin
            res_gcd_q    <= gcd_data_i;
            res_cycles_q <= cyc;
            state_q      <= eOUT;
          end else if (cyc == cycle_width_p'(timeout_p)) begin
            // Flag only; the job keeps waiting for its result.
            error_q <= 1'b1;
          end
        end
        eOUT: begin
          if (res_yumi_i) begin
            done_count_q <= done_count_q + 32'd1;
            state_q      <= eIDLE;
          end
        end
        default: state_q <= eIDLE;
      endcase
    end
  end

  assign gcd_a_o      = a_q;
  assign gcd_b_o      = b_q;
  assign res_a_o      = a_q;
  assign res_b_o      = b_q;
  assign res_gcd_o    = res_gcd_q;
  assign res_cycles_o = res_cycles_q;
  assign done_count_o = done_count_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_gcd_client.sv
// Bench for gcd_client with a behavioural gcd responder of programmable latency.
module tb_gcd_client;

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 4;
  localparam int unsigned TO   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic          job_v;
  logic [W-1:0]  job_a;
  logic [W-1:0]  job_b;
  logic          job_ready;
  logic          gcd_v_o;
  logic [W-1:0]  gcd_a;
  logic [W-1:0]  gcd_b;
  logic          gcd_ready;
  logic          gcd_v_i;
  logic [W-1:0]  gcd_data;
  logic          gcd_yumi;
  logic          res_v;
  logic [W-1:0]  res_a;
  logic [W-1:0]  res_b;
  logic [W-1:0]  res_gcd;
  logic [CW-1:0] res_cycles;
  logic          res_yumi;
  logic [31:0]   done_count;
  logic          error;

  int n_cmp = 0;
  int n_mis = 0;
  int unsigned model_done = 0;
  logic        model_err  = 1'b0;

  gcd_client #(
    .width_p       (W),
    .cycle_width_p (CW),
    .timeout_p     (TO)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .en_i         (en),
    .job_v_i      (job_v),
    .job_a_i      (job_a),
    .job_b_i      (job_b),
    .job_ready_o  (job_ready),
    .gcd_v_o      (gcd_v_o),
    .gcd_a_o      (gcd_a),
    .gcd_b_o      (gcd_b),
    .gcd_ready_i  (gcd_ready),
    .gcd_v_i      (gcd_v_i),
    .gcd_data_i   (gcd_data),
    .gcd_yumi_o   (gcd_yumi),
    .res_v_o      (res_v),
    .res_a_o      (res_a),
    .res_b_o      (res_b),
    .res_gcd_o    (res_gcd),
    .res_cycles_o (res_cycles),
    .res_yumi_i   (res_yumi),
    .done_count_o (done_count),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  // Euclid's algorithm; gcd(x,0)=x, gcd(0,0)=0.
  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full job: en held low en_hold cycles, gcd_ready low rdy_hold cycles,
  // result on the lat-th WAIT cycle, res_yumi after yumi_hold OUT cycles.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int en_hold,
                         input int rdy_hold, input int lat, input int yumi_hold, input bit noise);
    int           yumi_cnt;
    int unsigned  exp_cyc;
    logic [W-1:0] g;
    yumi_cnt = 0;
    g        = ref_gcd(a, b);
    exp_cyc  = (lat > int'(CMAX)) ? CMAX : lat;
    @(negedge clk);
    job_v = 1'b1;
    job_a = a;
    job_b = b;
    if (en_hold > 0) begin
      en = 1'b0;
      for (int i = 0; i < en_hold; i++) begin
        #1;
        check("ready_en_low", job_ready, 0);
        check("no_issue_en_low", gcd_v_o, 0);
        @(negedge clk);
      end
      en = 1'b1;
    end
    #1;
    check("job_ready", job_ready, 1);
    @(negedge clk);
    job_v = 1'b0;
    job_a = $urandom;
    job_b = $urandom;
    check("issue_v", gcd_v_o, 1);
    check("issue_a", gcd_a, a);
    check("issue_b", gcd_b, b);
    gcd_ready = 1'b0;
    for (int i = 0; i < rdy_hold; i++) begin
      @(negedge clk);
      check("hold_v", gcd_v_o, 1);
      check("hold_a", gcd_a, a);
      check("hold_b", gcd_b, b);
      check("hold_job_ready", job_ready, 0);
    end
    gcd_ready = 1'b1;
    @(negedge clk);
    gcd_ready = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      if (noise) en = 1'($urandom_range(0, 1));
      if (i == lat) begin
        gcd_v_i  = 1'b1;
        gcd_data = g;
      end
      #1;
      yumi_cnt += int'(gcd_yumi);
      check("wait_v_low", gcd_v_o, 0);
      check("wait_err", error, model_err | (i > int'(TO)));
      @(negedge clk);
      gcd_v_i = 1'b0;
    end
    en = 1'b1;
    if (lat > int'(TO)) model_err = 1'b1;
    for (int i = 0; i <= yumi_hold; i++) begin
      if (i == yumi_hold) res_yumi = 1'b1;
      if (noise) begin
        gcd_v_i  = 1'($urandom_range(0, 1));
        gcd_data = $urandom;
      end
      #1;
      yumi_cnt += int'(gcd_yumi);
      check("res_v", res_v, 1);
      check("res_a", res_a, a);
      check("res_b", res_b, b);
      check("res_gcd", res_gcd, g);
      check("res_cycles", res_cycles, exp_cyc);
      check("res_err", error, model_err);
      @(negedge clk);
      res_yumi = 1'b0;
      gcd_v_i  = 1'b0;
    end
    model_done++;
    check("yumi_once", yumi_cnt, 1);
    check("res_v_drop", res_v, 0);
    check("done_count", done_count, model_done);
    check("idle_ready", job_ready, 1);
  endtask

  initial begin
    reset_n   = 1'b0;
    en        = 1'b0;
    job_v     = 1'b0;
    job_a     = '0;
    job_b     = '0;
    gcd_ready = 1'b0;
    gcd_v_i   = 1'b0;
    gcd_data  = '0;
    res_yumi  = 1'b0;
    #1;
    check("rst_gcd_v", gcd_v_o, 0);
    check("rst_res_v", res_v, 0);
    check("rst_yumi", gcd_yumi, 0);
    check("rst_ready", job_ready, 0);
    check("rst_done", done_count, 0);
    check("rst_err", error, 0);
    check("rst_res_gcd", res_gcd, 0);
    check("rst_cycles", res_cycles, 0);
    @(negedge clk);
    reset_n = 1'b1;
    en      = 1'b1;

    run_job(32'd12, 32'd18, 0, 0, 1, 0, 1'b0);
    run_job(32'd100, 32'd75, 0, 10, 3, 2, 1'b0);
    run_job(32'd0, 32'd0, 3, 0, 2, 1, 1'b0);
    run_job(32'd0, 32'd5, 1, 0, 4, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom_range(1, 5000)) * 32'd6;
      rb = ($urandom_range(0, 3) == 0) ? $urandom : W'($urandom_range(0, 9000)) * 32'd4;
      run_job(ra, rb, $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(1, TO),
              $urandom_range(0, 2), 1'b1);
    end

    // Latency past the timeout sets the sticky flag; long waits saturate the count.
    run_job(32'd21, 32'd14, 0, 1, 5, 0, 1'b0);
    run_job(32'd48, 32'd36, 0, 0, 20, 1, 1'b0);

    // Asynchronous reset while a job waits for its result.
    @(negedge clk);
    job_v = 1'b1;
    job_a = 32'd9;
    job_b = 32'd6;
    @(negedge clk);
    job_v     = 1'b0;
    gcd_ready = 1'b1;
    @(negedge clk);
    gcd_ready = 1'b0;
    check("pre_rst_err", error, 1);
    #2;
    gcd_v_i = 1'b1;
    reset_n = 1'b0;
    #1;
    check("arst_gcd_v", gcd_v_o, 0);
    check("arst_yumi", gcd_yumi, 0);
    check("arst_res_v", res_v, 0);
    check("arst_done", done_count, 0);
    check("arst_err", error, 0);
    check("arst_a", gcd_a, 0);
    check("arst_res_b", res_b, 0);
    gcd_v_i = 1'b0;
    @(negedge clk);
    reset_n    = 1'b1;
    model_done = 0;
    model_err  = 1'b0;
    run_job(32'd7, 32'd0, 0, 0, 2, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
